alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu_32_bit` instance between two requesters. Each requester issues operands and an opcode over a valid/ready handshake. The block arbitrates between them, drives the operands into the combinational ALU, registers the result and zero flag, and returns them over a response handshake tagged with the winning requester's ID. It sits between the requesters and the ALU, and is the only driver of the ALU's `a`, `b` and `opCode` inputs.

## Interface
- `DATA_W`, 32: operand/result width; must match the ALU (32).
- `CNT_W`, 16: width of the completed-operation counter.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` in DATA_W: requester 0 operands.
- `req0_op` in 4: requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `alu_a`, `alu_b` out DATA_W: operands to the ALU.
- `alu_op` out 4: opCode to the ALU.
- `alu_result` in DATA_W: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out DATA_W: registered result.
- `rsp_zero` out 1: registered zero flag.
- `rsp_id` out 1: requester that issued the operation.
- `ops_done` out CNT_W: count of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - `reqN_ready` is asserted only in IDLE, and only for the granted requester (at most one per cycle); it is combinational from `reqN_valid` and `last_grant`.
  - If any `reqN_valid` is high, the operands, opcode and ID are latched from the winner, then go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - `alu_a`, `alu_b`, `alu_op` are driven from the latched registers.
  - At the end of the cycle, `alu_result` and `alu_zero` are captured into `rsp_result`/`rsp_zero`, then go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_result`, `rsp_zero` and `rsp_id` stay stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: increment `ops_done` and go to IDLE.
- **Arbitration:** round-robin, using a `last_grant` register (reset value 1, so requester 0 wins the first tie).
  - Both requesters valid: grant `!last_grant`.
  - One requester valid: grant it.
  - `last_grant` updates on every accepted request.
- **ALU drive outside EXEC:** the latched operand registers hold their last value, so the ALU inputs are stable but unused.
- **Reset values:** all outputs 0, state IDLE, `last_grant` 1, operand/opcode registers 0.
- **Reset mid-operation:** any in-flight operation is dropped, with no response and no counter increment. The next cycle is IDLE.
- **Requester deasserts valid while not granted:** no effect; nothing is latched.
- **`ops_done` at all-ones:** the next completion wraps it to 0.

## Timing
- Request accepted in cycle N → EXEC in N+1 → `rsp_valid` high in N+2.
- Response consumed in cycle M (`rsp_ready` high) → IDLE in M+1 → earliest next accept is M+1.
- Minimum issue interval is 3 cycles, achieved with `rsp_ready` held high.
- The ALU path is combinational within EXEC. The registered-operand → ALU → response-register path must close in one cycle.
- `rsp_*` outputs come from registers. `reqN_ready` is combinational from `reqN_valid`.

## Configuration
- **`ALU_ARB_RR_EN` defined:** round-robin arbitration as above.
- **`ALU_ARB_RR_EN` undefined:** fixed priority; requester 0 always wins when both are valid. `last_grant` is not implemented. Everything else is unchanged.

## Test plan
- Reset, then `req0` with a=5, b=3, op=ADD → `req0_ready` in cycle 0; `rsp_valid` in cycle 2 with result 8, zero 0, id 0; `ops_done`=1 after the handshake.
- Both requesters valid from reset, `rsp_ready`=1 → grants alternate 0,1,0,1 with RR (always 0 when `ALU_ARB_RR_EN` is undefined); each response carries the correct operands' result.
- `req1` op=SUB, a=b=0x1234 → `rsp_result`=0, `rsp_zero`=1, `rsp_id`=1.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`, `rsp_result` and `rsp_id` stable; `reqN_ready` stays 0; `ops_done` is unchanged until the handshake.
- `reset` asserted in EXEC → next cycle all outputs 0, state IDLE; no response ever appears for the dropped operation.
- `CNT_W`=4: complete 16 operations → `ops_done` wraps to 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals for alu_arbiter, with arbiter-side (slave)
// and environment-side (master) modports.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_id;
  logic [CNT_W-1:0]  ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_zero, rsp_id, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_zero, rsp_id, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational 32-bit ALU: IDLE/EXEC/RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [3:0]        op_reg;
  logic              id_reg;
  logic [DATA_W-1:0] rsp_result_reg;
  logic              rsp_zero_reg;
  logic [CNT_W-1:0]  ops_done_reg;

  logic any_valid;
  logic grant;
  logic accept;
  logic rsp_fire;

  assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_RR_EN
  logic last_grant_reg;

  // A lone requester wins outright; a tie goes to whoever did not win last.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant;
    end
  end
`else
  assign grant = ~bus.req0_valid;
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid && !reset) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      id_reg         <= 1'b0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      ops_done_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg  <= grant ? bus.req1_a  : bus.req0_a;
        b_reg  <= grant ? bus.req1_b  : bus.req0_b;
        op_reg <= grant ? bus.req1_op : bus.req0_op;
        id_reg <= grant;
      end
      // The ALU is combinational, so its output is settled by the end of EXEC.
      if (state_reg == EXEC) begin
        rsp_result_reg <= bus.alu_result;
        rsp_zero_reg   <= bus.alu_zero;
      end
      if (rsp_fire) begin
        ops_done_reg <= ops_done_reg + 1'b1;
      end
    end
  end

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  assign bus.alu_a  = a_reg;
  assign bus.alu_b  = b_reg;
  assign bus.alu_op = op_reg;

  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_zero   = rsp_zero_reg;
  assign bus.rsp_id     = id_reg;
  assign bus.ops_done   = ops_done_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table with a reference ALU, plus
// back-pressure, reset-in-EXEC and counter-wrap sequences (CNT_W = 4).
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic [3:0]  op0;
    logic [31:0] a1, b1;
    logic [3:0]  op1;
    logic        id_rr, id_fp;
    logic [31:0] res0, res1;
    logic        z0, z1;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_done = 0;
  vec_t vecs[8];

  alu_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared alu_32_bit.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      OP_AND:  alu_res = bus.alu_a & bus.alu_b;
      OP_OR:   alu_res = bus.alu_a | bus.alu_b;
      OP_ADD:  alu_res = bus.alu_a + bus.alu_b;
      OP_SUB:  alu_res = bus.alu_a - bus.alu_b;
      OP_SLT:  alu_res = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      OP_NOR:  alu_res = ~(bus.alu_a | bus.alu_b);
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero   = (alu_res == '0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the DUT in IDLE and rsp_ready high.
  task automatic run_vec(input vec_t v, input int n);
    logic        eid;
    logic [31:0] eres;
    logic [31:0] ea;
    logic [3:0]  eop;
    logic        ez;
`ifdef ALU_ARB_RR_EN
    eid = v.id_rr;
`else
    eid = v.id_fp;
`endif
    eres = eid ? v.res1 : v.res0;
    ez   = eid ? v.z1   : v.z0;
    ea   = eid ? v.a1   : v.a0;
    eop  = eid ? v.op1  : v.op0;
    bus.req0_valid = v.v0;
    bus.req0_a     = v.a0;
    bus.req0_b     = v.b0;
    bus.req0_op    = v.op0;
    bus.req1_valid = v.v1;
    bus.req1_a     = v.a1;
    bus.req1_b     = v.b1;
    bus.req1_op    = v.op1;
    bus.rsp_ready  = 1'b1;
    #1;
    check("grant_ready", 32'({bus.req1_ready, bus.req0_ready}), eid ? 32'd2 : 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_alu_a", bus.alu_a, ea);
    check("exec_alu_op", 32'(bus.alu_op), 32'(eop));
    tick();
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_result", bus.rsp_result, eres);
    check("rsp_zero", 32'(bus.rsp_zero), 32'(ez));
    check("rsp_id", 32'(bus.rsp_id), 32'(eid));
    check("ops_done_before", 32'(bus.ops_done), 32'(exp_done));
    $display("txn %0d: id=%0d result=0x%08h zero=%0b ops_done=%0d",
             n, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.ops_done);
    tick();
    exp_done = (exp_done + 1) % 16;
    check("ops_done_after", 32'(bus.ops_done), 32'(exp_done));
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    check({tag, "_rsp_zero"},   32'(bus.rsp_zero), 32'd0);
    check({tag, "_rsp_id"},     32'(bus.rsp_id), 32'd0);
    check({tag, "_ops_done"},   32'(bus.ops_done), 32'd0);
    check({tag, "_alu_a"},      bus.alu_a, 32'd0);
    check({tag, "_alu_b"},      bus.alu_b, 32'd0);
    check({tag, "_alu_op"},     32'(bus.alu_op), 32'd0);
    check({tag, "_ready"},      32'({bus.req1_ready, bus.req0_ready}), 32'd0);
  endtask

  initial begin
    vec_t w;
    //          v0    v1    a0           b0      op0     a1           b1            op1     rr    fp    res0          res1          z0    z1
    vecs[0] = '{1'b1, 1'b1, 32'd5,       32'd3,  OP_ADD, 32'd7,       32'd3,        OP_AND, 1'b0, 1'b0, 32'd8,        32'd3,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'd10,      32'd4,  OP_SUB, 32'hF0,      32'h0F,       OP_OR,  1'b1, 1'b0, 32'd6,        32'hFF,       1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0F,      32'hF0, OP_AND, 32'd1,       32'd1,        OP_ADD, 1'b0, 1'b0, 32'd0,        32'd2,        1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'd3,       32'd5,  OP_SLT, 32'd0,       32'd0,        OP_NOR, 1'b1, 1'b0, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0,       32'd0,        OP_ADD, 1'b0, 1'b0, 32'd0,        32'd0,        1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'd0,       32'd0,  OP_ADD, 32'h1234,    32'h1234,     OP_SUB, 1'b1, 1'b1, 32'd0,        32'd0,        1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'd0,       32'd0,  OP_ADD, 32'd100,     32'd1,        OP_SUB, 1'b1, 1'b1, 32'd0,        32'd99,       1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'd2,       32'd2,  OP_ADD, 32'd9,       32'd6,        OP_OR,  1'b0, 1'b0, 32'd4,        32'd15,       1'b0, 1'b0};

    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_op    = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_op    = '0;
    bus.rsp_ready  = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-pressure: response held for 5 cycles while requester 1 waits.
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'd1;
    bus.req0_b     = 32'd2;
    bus.req0_op    = OP_ADD;
    bus.rsp_ready  = 1'b0;
    #1;
    check("bp_accept", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'd50;
    bus.req1_b     = 32'd1;
    bus.req1_op    = OP_ADD;
    #1;
    check("bp_exec_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_result", bus.rsp_result, 32'd3);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check("bp_ops_done", 32'(bus.ops_done), 32'(exp_done));
      tick();
    end
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    #1;
    check("bp_rsp_valid_last", 32'(bus.rsp_valid), 32'd1);
    $display("txn bp: id=%0d result=0x%08h zero=%0b", bus.rsp_id, bus.rsp_result, bus.rsp_zero);
    tick();
    exp_done = (exp_done + 1) % 16;
    check("bp_ops_done_after", 32'(bus.ops_done), 32'(exp_done));
    check("bp_idle", 32'(bus.rsp_valid), 32'd0);

    // Reset while the operation sits in EXEC: dropped without a response.
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h55;
    bus.req1_b     = 32'h22;
    bus.req1_op    = OP_ADD;
    #1;
    check("rst_accept", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_done = 0;
    check_all_zero("rst_exec");
    $display("txn reset-in-exec: operation dropped");
    for (int k = 0; k < 6; k++) begin
      check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    check("rst_ops_done", 32'(bus.ops_done), 32'd0);

    // 16 completions wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) begin
      w = '{1'b1, 1'b0, 32'(i * 3), 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD,
            1'b0, 1'b0, 32'(i * 3 + 7), 32'd0, 1'b0, 1'b1};
      run_vec(w, 100 + i);
    end
    check("ops_done_wrap", 32'(bus.ops_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
